mips_mem_bridge: RTL and testbench
==================================

// Module: mips_mem_bridge
// PURPOSE
// - Memory-side responder for the multicycle MIPS control unit's memory port (IorD/MemWrite/IrWrite path).
// - Converts the CPU's level-held read/write request into a single-outstanding Avalon-MM master transaction.
// - Generates the `stall` input that holds the control FSM in EXEC_1.
// - Returns latched read data for the instruction or data register.
// PARAMETERS
// - ADDR_W          32    Address width on both sides.
// - TIMEOUT_CYCLES  1023  Cycles in CMD+RESP before abort. Used only with MIPS_MEM_BRIDGE_TIMEOUT_EN.
// PORTS
// - clk               in   1       Clock.
// - Rst               in   1       Synchronous, active-high reset.
// - cpu_addr          in   ADDR_W  Byte address from the ALUOut/PC mux.
// - cpu_read          in   1       Read request. Level, held until stall is low.
// - cpu_write         in   1       Write request (MemWrite). Level, held until stall is low.
// - cpu_wdata         in   32      Write data (register B).
// - cpu_byteen        in   4       Byte enables. 4'hF for word ops.
// - cpu_stall         out  1       High while the request is unfinished. Combinational in IDLE.
// - cpu_rdata         out  32      Last completed read data (registered).
// - cpu_done          out  1       One-cycle pulse when the transaction completes.
// - cpu_err           out  1       One-cycle abort pulse. Tied 0 without the macro.
// - avm_address       out  ADDR_W  Word-aligned: {cpu_addr[ADDR_W-1:2], 2'b00}.
// - avm_read          out  1       Avalon read strobe.
// - avm_write         out  1       Avalon write strobe.
// - avm_writedata     out  32      Latched cpu_wdata.
// - avm_byteenable    out  4       Latched cpu_byteen.
// - avm_waitrequest   in   1       Slave not ready. Command is held while this is high.
// - avm_readdata      in   32      Read data. Valid when avm_readdatavalid is high.
// - avm_readdatavalid in   1       Read response strobe. Any latency of 0 or more cycles after acceptance.
// BEHAVIOUR
// - Reset: state IDLE. Registered outputs cleared on the next clk edge:
//   - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
//   - cpu_rdata=0, cpu_done=0, cpu_err=0. Timeout counter=0.
// - FSM states: IDLE, CMD, RESP, DONE.
// - IDLE:
//   - req = cpu_read | cpu_write. cpu_stall = req, combinationally, so the control FSM holds in EXEC_1.
//   - On req: latch address, data and byteenable; select write if cpu_write else read. Go to CMD.
//   - cpu_read and cpu_write both high: treated as a write, read ignored.
// - CMD:
//   - Strobe (avm_read or avm_write) held high with stable address/data while avm_waitrequest=1.
//   - Accept = strobe & !avm_waitrequest. Strobe drops on the edge after accept.
//   - Write accepted -> DONE.
//   - Read accepted with avm_readdatavalid already high in the same cycle -> latch data, DONE.
//   - Read accepted otherwise -> RESP.
// - RESP:
//   - No strobes. On avm_readdatavalid: cpu_rdata <= avm_readdata, go to DONE.
// - DONE:
//   - cpu_stall=0, cpu_done=1 for exactly one cycle. The control FSM advances on this edge.
//   - Unconditionally returns to IDLE. A still-held request is not re-issued.
// - cpu_stall = (IDLE & req) | CMD | RESP. Low in DONE.
// - Minimum latency, request to cpu_done: 2 cycles (IDLE->CMD->DONE, waitrequest=0, readdatavalid with accept).
// - cpu_rdata is held between reads. Writes never modify it.
// - avm_readdatavalid in IDLE, CMD-before-accept, or DONE: ignored, no state change.
// - Rst mid-transaction (any state): strobes and cpu_stall drop.
//   - A late readdatavalid for the aborted read is dropped.
//   - cpu_done is not pulsed.
// CONFIGURATION
// - MIPS_MEM_BRIDGE_TIMEOUT_EN defined:
//   - A counter runs in CMD/RESP and is cleared on entering CMD.
//   - When the count reaches TIMEOUT_CYCLES: strobes drop, FSM goes to DONE, cpu_err=1 with cpu_done=1.
//   - cpu_rdata <= 32'hDEAD_BEEF on a read abort.
// - Not defined: no counter. CMD/RESP wait indefinitely. cpu_err is constant 0.
// TESTING
// - Read, addr=0x0000_1006, waitrequest=0, readdatavalid same cycle, data=0x1234_5678:
//   avm_address=0x1004, stall high 2 cycles, cpu_done then cpu_rdata=0x12345678.
// - Write, addr=0x20, wdata=0xCAFE_F00D, byteen=4'h3, waitrequest high 3 cycles:
//   avm_write held 4 cycles with stable data, cpu_done on the 5th cycle, cpu_rdata unchanged.
// - Read, readdatavalid 5 cycles after accept: FSM sits in RESP, stall stays high, then cpu_done.
//   A stray readdatavalid in IDLE leaves cpu_rdata unchanged.
// - cpu_read=cpu_write=1: only avm_write is asserted. Request held through DONE: exactly one Avalon transaction.
// - Rst pulsed while in RESP, then readdatavalid arrives: state IDLE, no cpu_done, cpu_rdata=0.
// - With the macro, TIMEOUT_CYCLES=8, waitrequest stuck high: abort after 8 cycles in CMD.
//   cpu_err=cpu_done=1 for one cycle, cpu_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/mips_mem_bridge_if.sv
// Bus bundle between the multicycle MIPS memory port, the bridge and an Avalon-MM slave.
// The master modport is the bridge's view; the slave modport is the CPU plus memory environment.
interface mips_mem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_byteen;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        input  cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_byteen,
        output cpu_stall, cpu_rdata, cpu_done, cpu_err,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        output cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_byteen,
        input  cpu_stall, cpu_rdata, cpu_done, cpu_err,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mips_mem_bridge.sv
// Turns the MIPS control unit's level-held memory request into one Avalon-MM transaction.
// Optional abort timer: define MIPS_MEM_BRIDGE_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mips_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                Rst,
    mips_mem_bridge_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   req_s;
    logic   accept_s;
    logic   load_rdata_s;
    logic   abort_s;
    logic   err_s;
    logic   rd_sel_r;

    assign req_s = bus.cpu_read | bus.cpu_write;

`ifdef MIPS_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r;

    // Cycle counter for the outstanding command; restarts whenever the bridge is idle.
    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == CMD) || (state_r == RESP)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign abort_s = ((state_r == CMD) || (state_r == RESP)) &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error pulse accompanies the abort's cpu_done.
    always_ff @(posedge clk) begin
        if (Rst) begin
            bus.cpu_err <= 1'b0;
        end else begin
            bus.cpu_err <= err_s;
        end
    end
`else
    assign abort_s     = 1'b0;
    assign bus.cpu_err = 1'b0;
`endif

    // Stall is combinational in IDLE so the control FSM holds in the very cycle it asks.
    assign bus.cpu_stall = ((state_r == IDLE) && req_s) || (state_r == CMD) || (state_r == RESP);

    // Next-state decode; a normal completion wins over a timeout in the same cycle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        load_rdata_s = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    next_state_s = CMD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CMD: begin
                accept_s = (bus.avm_read | bus.avm_write) & ~bus.avm_waitrequest;
                if (accept_s && bus.avm_write) begin
                    next_state_s = DONE;
                end else if (accept_s && bus.avm_readdatavalid) begin
                    load_rdata_s = 1'b1;
                    next_state_s = DONE;
                end else if (accept_s) begin
                    next_state_s = RESP;
                end else if (abort_s) begin
                    err_s        = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = CMD;
                end
            end
            RESP: begin
                if (bus.avm_readdatavalid) begin
                    load_rdata_s = 1'b1;
                    next_state_s = DONE;
                end else if (abort_s) begin
                    err_s        = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RESP;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register, Avalon command registers and CPU-side result registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r            <= IDLE;
            rd_sel_r           <= 1'b0;
            bus.avm_read       <= 1'b0;
            bus.avm_write      <= 1'b0;
            bus.avm_address    <= {ADDR_W{1'b0}};
            bus.avm_writedata  <= 32'h0000_0000;
            bus.avm_byteenable <= 4'h0;
            bus.cpu_rdata      <= 32'h0000_0000;
            bus.cpu_done       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            bus.cpu_done <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        bus.avm_address    <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                        bus.avm_writedata  <= bus.cpu_wdata;
                        bus.avm_byteenable <= bus.cpu_byteen;
                        bus.avm_write      <= bus.cpu_write;
                        bus.avm_read       <= ~bus.cpu_write;
                        rd_sel_r           <= ~bus.cpu_write;
                    end
                end
                CMD: begin
                    if (next_state_s != CMD) begin
                        bus.avm_read  <= 1'b0;
                        bus.avm_write <= 1'b0;
                    end
                end
                default: begin
                    bus.avm_read  <= 1'b0;
                    bus.avm_write <= 1'b0;
                end
            endcase
            if (load_rdata_s) begin
                bus.cpu_rdata <= bus.avm_readdata;
            end else if (err_s && rd_sel_r) begin
                bus.cpu_rdata <= 32'hDEAD_BEEF;
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Randomized bench for mips_mem_bridge: an Avalon slave driven per transaction, results
// compared against a transaction-level model of latency, strobes and the read-data register.
module tb_mips_mem_bridge;
    logic clk = 1'b0;
    logic Rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] ref_rdata;

    always #5 clk = ~clk;

    mips_mem_bridge_if #(.ADDR_W(32)) bus ();

    mips_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_strobes"}, {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, bus.cpu_done}, 32'd0);
        check_eq({tag, "_stall"}, {31'd0, bus.cpu_stall}, 32'd0);
    endtask

    // One CPU request; w = waitrequest cycles, l = readdatavalid latency after accept.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int w, input int l, input logic [31:0] rdata);
        bit          is_wr;
        logic [31:0] exp_addr;
        is_wr    = wr;
        exp_addr = {addr[31:2], 2'b00};
        bus.cpu_addr          = addr;
        bus.cpu_read          = rd;
        bus.cpu_write         = wr;
        bus.cpu_wdata         = wdata;
        bus.cpu_byteen        = be;
        bus.avm_waitrequest   = 1'b1;
        bus.avm_readdatavalid = 1'b0;
        #1;
        check_eq("stall_idle", {31'd0, bus.cpu_stall}, 32'd1);
        check_eq("strobe_idle", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
        @(negedge clk);
        for (int i = 0; i <= w; i++) begin
            check_eq("stall_cmd", {31'd0, bus.cpu_stall}, 32'd1);
            check_eq("avm_write", {31'd0, bus.avm_write}, {31'd0, is_wr});
            check_eq("avm_read", {31'd0, bus.avm_read}, {31'd0, ~is_wr});
            check_eq("avm_address", bus.avm_address, exp_addr);
            if (is_wr) begin
                check_eq("avm_writedata", bus.avm_writedata, wdata);
                check_eq("avm_byteenable", {28'd0, bus.avm_byteenable}, {28'd0, be});
            end
            bus.avm_waitrequest = (i < w);
            if (i < w) begin
                bus.avm_readdatavalid = 1'($urandom_range(0, 1));
                bus.avm_readdata      = $urandom;
            end else if (!is_wr && l == 0) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = rdata;
            end else begin
                bus.avm_readdatavalid = 1'b0;
            end
            @(negedge clk);
        end
        bus.avm_waitrequest   = 1'b1;
        bus.avm_readdatavalid = 1'b0;
        if (!is_wr) begin
            for (int j = 1; j <= l; j++) begin
                check_eq("stall_resp", {31'd0, bus.cpu_stall}, 32'd1);
                check_eq("strobe_resp", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
                check_eq("done_resp", {31'd0, bus.cpu_done}, 32'd0);
                bus.avm_readdatavalid = (j == l);
                bus.avm_readdata      = (j == l) ? rdata : $urandom;
                @(negedge clk);
            end
            ref_rdata = rdata;
        end
        bus.avm_readdatavalid = 1'b0;
        // DONE: request still held by the CPU during this cycle.
        check_eq("done", {31'd0, bus.cpu_done}, 32'd1);
        check_eq("err", {31'd0, bus.cpu_err}, 32'd0);
        check_eq("stall_done", {31'd0, bus.cpu_stall}, 32'd0);
        check_eq("strobe_done", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
        check_eq("rdata", bus.cpu_rdata, ref_rdata);
        @(negedge clk);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        #1;
        check_quiet("after_done");
        if ($urandom_range(0, 2) == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = $urandom;
            @(negedge clk);
            bus.avm_readdatavalid = 1'b0;
            check_eq("stray_idle_rdata", bus.cpu_rdata, ref_rdata);
            check_quiet("stray_idle");
        end
        @(negedge clk);
    endtask

    initial begin
        Rst                   = 1'b1;
        bus.cpu_addr          = 32'd0;
        bus.cpu_read          = 1'b0;
        bus.cpu_write         = 1'b0;
        bus.cpu_wdata         = 32'd0;
        bus.cpu_byteen        = 4'h0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = 32'd0;
        bus.avm_readdatavalid = 1'b0;
        ref_rdata             = 32'd0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_err", {31'd0, bus.cpu_err}, 32'd0);
        check_eq("reset_rdata", bus.cpu_rdata, 32'd0);
        check_eq("reset_address", bus.avm_address, 32'd0);
        check_eq("reset_writedata", bus.avm_writedata, 32'd0);
        check_eq("reset_byteenable", {28'd0, bus.avm_byteenable}, 32'd0);
        Rst = 1'b0;
        @(negedge clk);

        do_txn(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 32'h1234_5678);
        do_txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3, 0, 32'h0);
        do_txn(1'b1, 1'b0, 32'h0000_0444, 32'h0, 4'hF, 0, 5, 32'hA5A5_0001);
        do_txn(1'b1, 1'b1, 32'h0000_0FFF, 32'h0BAD_F00D, 4'hF, 1, 2, 32'h0);

        // Reset while waiting in RESP; the late response must be dropped.
        bus.cpu_addr = 32'h0000_0100;
        bus.cpu_read = 1'b1;
        @(negedge clk);
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        @(negedge clk);
        check_eq("rst_resp_stall", {31'd0, bus.cpu_stall}, 32'd1);
        Rst          = 1'b1;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        Rst                   = 1'b0;
        ref_rdata             = 32'd0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h7777_7777;
        #1;
        check_quiet("rst_mid");
        @(negedge clk);
        bus.avm_readdatavalid = 1'b0;
        check_quiet("rst_late_rdv");
        check_eq("rst_rdata", bus.cpu_rdata, ref_rdata);
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            do_txn(rd, wr, $urandom, $urandom, 4'($urandom_range(1, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

`ifdef MIPS_MEM_BRIDGE_TIMEOUT_EN
        // Slave never accepts: abort after 8 cycles in CMD.
        bus.cpu_addr        = 32'h0000_0200;
        bus.cpu_read        = 1'b1;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq("to_avm_read", {31'd0, bus.avm_read}, 32'd1);
            check_eq("to_done_early", {31'd0, bus.cpu_done}, 32'd0);
            @(negedge clk);
        end
        ref_rdata = 32'hDEAD_BEEF;
        check_eq("to_done", {31'd0, bus.cpu_done}, 32'd1);
        check_eq("to_err", {31'd0, bus.cpu_err}, 32'd1);
        check_eq("to_rdata", bus.cpu_rdata, ref_rdata);
        check_eq("to_strobe", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
        @(negedge clk);
        bus.cpu_read = 1'b0;
        #1;
        check_eq("to_err_clear", {31'd0, bus.cpu_err}, 32'd0);
        check_quiet("to_after");
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
